systema_ram_copier: RTL and testbench

//  Avalon-MM master that copies a block of 32-bit words within the on-chip RAM (11-bit word address, 4 byte lanes).

---
 rtl/systema_ram_copier_pkg.sv | 17 +
 rtl/systema_ram_copier_if.sv | 30 +++
 rtl/systema_ram_copier_lat.sv | 29 ++
 rtl/systema_ram_copier.sv | 120 ++++++++++++
 tb/tb_systema_ram_copier.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/systema_ram_copier_pkg.sv
// Shared definitions for the on-chip RAM block copier.
// Holds the RAM geometry defaults and the copier FSM state encoding.
package systema_ram_copier_pkg;

    localparam int RAM_ADDR_W = 11;   // word address; wraps modulo 2**RAM_ADDR_W
    localparam int RAM_DATA_W = 32;   // word width, 4 byte lanes
    localparam int RAM_LEN_W  = 12;   // wide enough to hold a full-RAM length (2048)

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

endpackage

// File: rtl/systema_ram_copier_if.sv
// Avalon-MM bus between the copier (master) and the RAM s1/s2 port (slave).
//   avm_address/chipselect/read/write/byteenable/writedata : master -> slave
//   avm_readdata/avm_waitrequest                           : slave  -> master
interface systema_ram_copier_if
    import systema_ram_copier_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_chipselect;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_waitrequest;

    modport master (
        output avm_address, avm_chipselect, avm_read, avm_write,
               avm_byteenable, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_read, avm_write,
               avm_byteenable, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/systema_ram_copier_lat.sv
// Read-latency timer: loaded when a read is accepted, it counts down and
// raises valid in the cycle where avm_readdata carries the returned word.
//   clk, reset_n : clock, async active-low reset
//   load         : read accepted this cycle
//   valid        : readdata is valid this cycle
module systema_ram_copier_lat #(
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic valid
);
    localparam int CW = $clog2(READ_LATENCY + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= CW'(READ_LATENCY);
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    // Count 1 is the READ_LATENCY-th cycle after the accept.
    assign valid = (cnt == CW'(1));
endmodule

// File: rtl/systema_ram_copier.sv
// Avalon-MM master that copies a block of words inside the on-chip RAM,
// one read/write pair per word, always running forward from the lowest
// address with source and destination wrapping modulo 2**ADDR_W.
//   clk, reset_n              : clock, async active-low reset
//   start                     : command strobe, honoured only when idle
//   src_addr, dst_addr, length: copy parameters, latched on start
//   busy                      : copy in progress
//   done                      : one-cycle completion pulse
//   avm                       : RAM master port (systema_ram_copier_if.master)
module systema_ram_copier
    import systema_ram_copier_pkg::*;
#(
    parameter int ADDR_W       = RAM_ADDR_W,
    parameter int DATA_W       = RAM_DATA_W,
    parameter int LEN_W        = RAM_LEN_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    systema_ram_copier_if.master avm
);
    state_t            state, next_state;
    logic [ADDR_W-1:0] src_cnt, dst_cnt;
    logic [LEN_W-1:0]  rem_cnt;
    logic [DATA_W-1:0] wdata;
    logic              done_q;
    logic              rd_accept, wr_accept, data_vld, last_word;

    assign rd_accept = (state == ST_RD_REQ) && !avm.avm_waitrequest;
    assign wr_accept = (state == ST_WR_REQ) && !avm.avm_waitrequest;
    assign last_word = (rem_cnt == LEN_W'(1));

    systema_ram_copier_lat #(
        .READ_LATENCY (READ_LATENCY)
    ) u_lat (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (rd_accept),
        .valid   (data_vld)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:    if (start) next_state = (length == '0) ? ST_FINISH : ST_RD_REQ;
            ST_RD_REQ:  if (!avm.avm_waitrequest) next_state = ST_RD_WAIT;
            ST_RD_WAIT: if (data_vld) next_state = ST_WR_REQ;
            ST_WR_REQ:  if (!avm.avm_waitrequest) next_state = last_word ? ST_FINISH : ST_RD_REQ;
            ST_FINISH:  next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Output decode: requests are pure functions of the state, so they stay
    // stable for as long as the slave holds waitrequest, and they drop the
    // instant reset forces the state back to idle.
    always_comb begin
        avm.avm_read    = 1'b0;
        avm.avm_write   = 1'b0;
        avm.avm_address = '0;
        case (state)
            ST_RD_REQ: begin
                avm.avm_read    = 1'b1;
                avm.avm_address = src_cnt;
            end
            ST_WR_REQ: begin
                avm.avm_write   = 1'b1;
                avm.avm_address = dst_cnt;
            end
            default: ;
        endcase
        avm.avm_chipselect = avm.avm_read | avm.avm_write;
        avm.avm_byteenable = avm.avm_chipselect ? '1 : '0;
        busy               = (state != ST_IDLE);
    end

    assign avm.avm_writedata = wdata;
    assign done              = done_q;

    // Datapath. done is registered off FINISH, so the pulse lands one cycle
    // after FINISH, when busy has already dropped (start-to-done = 3*len+2).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_cnt <= '0;
            dst_cnt <= '0;
            rem_cnt <= '0;
            wdata   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == ST_FINISH);
            if (state == ST_IDLE && start) begin
                src_cnt <= src_addr;
                dst_cnt <= dst_addr;
                rem_cnt <= length;
            end
            if (state == ST_RD_WAIT && data_vld)
                wdata <= avm.avm_readdata;
            if (wr_accept) begin
                src_cnt <= src_cnt + ADDR_W'(1);
                dst_cnt <= dst_cnt + ADDR_W'(1);
                rem_cnt <= rem_cnt - LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_systema_ram_copier.sv
// Self-checking bench for systema_ram_copier: RAM model with 1-cycle read
// latency and programmable waitrequest, table-driven directed copies,
// hand-written reset sequence, and randomized copies against a word-level
// reference memory.
module tb_systema_ram_copier;
    import systema_ram_copier_pkg::*;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int LW = 12;
    localparam int NW = 2048;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done;

    systema_ram_copier_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    systema_ram_copier #(
        .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .READ_LATENCY(1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .avm      (bus)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(int i);
        if (i >= 16 && i < 20) return 32'hA0 + 32'(i - 16);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    // ---------------- RAM model + bus monitors ----------------
    logic [DW-1:0] mem [NW];
    logic [DW-1:0] rdata_q;
    bit            mem_ready;
    int            stall_n;
    bit            rand_stall;
    int            stall_left;
    int            done_cnt, wr_acc, req_cnt;

    assign bus.avm_readdata    = rdata_q;
    assign bus.avm_waitrequest = (bus.avm_read || bus.avm_write) && (stall_left != 0);

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < NW; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (bus.avm_chipselect && !bus.avm_waitrequest) begin
            if (bus.avm_write) mem[bus.avm_address] <= bus.avm_writedata;
            if (bus.avm_read)  rdata_q <= mem[bus.avm_address];
        end
        if ((bus.avm_read || bus.avm_write) && stall_left != 0)
            stall_left <= stall_left - 1;
        else
            stall_left <= rand_stall ? int'($urandom_range(0, 3)) : stall_n;
        if (done) done_cnt <= done_cnt + 1;
        if (bus.avm_write && !bus.avm_waitrequest) wr_acc <= wr_acc + 1;
        if (bus.avm_read || bus.avm_write) req_cnt <= req_cnt + 1;
    end

    logic [51:0] outs;
    assign outs = {busy, done, bus.avm_read, bus.avm_write, bus.avm_chipselect,
                   bus.avm_address, bus.avm_writedata, bus.avm_byteenable};

    // ---------------- checking ----------------
    logic [DW-1:0] ref_mem [NW];
    int errors, checks;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_mem(input string tag);
        int bad = 0;
        int first = 0;
        for (int i = NW - 1; i >= 0; i--)
            if (mem[i] !== ref_mem[i]) begin bad++; first = i; end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mem_%s: %0d words differ, first at %0d got %h expected %h",
                     tag, bad, first, mem[first], ref_mem[first]);
        end
    endtask

    // One copy: update reference, pulse start, watch protocol until done.
    // stall < 0 means random stalls (request count not predicted);
    // exp_cyc < 0 means cycle count not predicted.
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [LW-1:0] n, input int stall, input bit poke,
                            input int exp_cyc, input string tag);
        int t0, wr0, dn0, rq0, got;
        bit seen, busy_bad, excl_bad, cs_bad, stab_bad, prev_stall;
        logic [48:0] prev_bus, cur_bus;
        for (int i = 0; i < int'(n); i++)
            ref_mem[(int'(d) + i) % NW] = ref_mem[(int'(s) + i) % NW];
        @(negedge clk);
        src_addr = s; dst_addr = d; length = n; start = 1'b1;
        t0 = cyc; wr0 = wr_acc; dn0 = done_cnt; rq0 = req_cnt;
        got = -1; seen = 0; busy_bad = 0; excl_bad = 0; cs_bad = 0; stab_bad = 0;
        prev_stall = 0; prev_bus = '0;
        for (int k = 0; k < int'(n) * 9 + 20 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (poke && k == 3) begin
                start = 1'b1; src_addr = ~s; dst_addr = 11'h7F0; length = 12'd5;
            end
            if (poke && k == 4) start = 1'b0;
            cur_bus = {bus.avm_read, bus.avm_write, bus.avm_address,
                       bus.avm_writedata, bus.avm_byteenable};
            if (done) begin
                seen = 1; got = cyc - t0;
                if (busy) busy_bad = 1;
            end else if (!busy) busy_bad = 1;
            if (bus.avm_read && bus.avm_write) excl_bad = 1;
            if (bus.avm_chipselect !== (bus.avm_read | bus.avm_write) ||
                bus.avm_byteenable !== (bus.avm_chipselect ? 4'hF : 4'h0)) cs_bad = 1;
            if (prev_stall && cur_bus !== prev_bus) stab_bad = 1;
            prev_stall = (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
            prev_bus = cur_bus;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (exp_cyc >= 0) chk({tag, "_cycles"}, 64'(got), 64'(exp_cyc));
        chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
        chk({tag, "_rw_excl"}, 64'(excl_bad), 64'd0);
        chk({tag, "_cs_be"}, 64'(cs_bad), 64'd0);
        chk({tag, "_stall_stable"}, 64'(stab_bad), 64'd0);
        repeat (4) @(negedge clk);
        chk({tag, "_done_pulses"}, 64'(done_cnt - dn0), 64'd1);
        chk({tag, "_writes"}, 64'(wr_acc - wr0), 64'(n));
        if (stall >= 0)
            chk({tag, "_requests"}, 64'(req_cnt - rq0), 64'(int'(n) * (2 * stall + 2)));
        chk_mem(tag);
    endtask

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [LW-1:0] len;
        int            stall;
        bit            poke;
        int            exp_cyc;
    } vec_t;

    vec_t vecs [7];

    initial begin : main
        int  wr0, dn0;
        bit  found;
        logic [AW-1:0] rs, rd;
        logic [LW-1:0] rn;

        vecs[0] = '{11'h010, 11'h040, 12'd4, 0, 1'b0, 14};  // basic
        vecs[1] = '{11'h080, 11'h0C0, 12'd2, 3, 1'b0, 20};  // stalled
        vecs[2] = '{11'h200, 11'h210, 12'd0, 0, 1'b0, 2};   // zero length
        vecs[3] = '{11'd2046, 11'h000, 12'd3, 0, 1'b0, 11}; // wrap
        vecs[4] = '{11'h100, 11'h101, 12'd4, 1, 1'b0, 22};  // overlap
        vecs[5] = '{11'h300, 11'h340, 12'd3, 0, 1'b1, 11};  // start while busy
        vecs[6] = '{11'h400, 11'h500, 12'd1, 2, 1'b0, 9};

        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
        stall_n = 0; rand_stall = 0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(outs), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            stall_n = vecs[i].stall;
            run_copy(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].stall,
                     vecs[i].poke, vecs[i].exp_cyc, $sformatf("vec%0d", i));
            if (i == 0)
                for (int w = 0; w < 4; w++)
                    chk($sformatf("basic_word%0d", w), 64'(mem[64 + w]), 64'(32'hA0 + 32'(w)));
            if (i == 3) begin
                chk("wrap_w0", 64'(mem[0]), 64'(init_word(2046)));
                chk("wrap_w1", 64'(mem[1]), 64'(init_word(2047)));
                chk("wrap_w2", 64'(mem[2]), 64'(init_word(2046)));
            end
        end

        // Reset during the second write of a 4-word copy.
        stall_n = 0;
        ref_mem[11'h700] = ref_mem[11'h600];
        @(negedge clk);
        src_addr = 11'h600; dst_addr = 11'h700; length = 12'd4; start = 1'b1;
        wr0 = wr_acc; dn0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (bus.avm_write && (wr_acc - wr0) == 1) found = 1;
            else @(negedge clk);
        end
        chk("rst_second_write_reached", 64'(found), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_outputs", 64'(outs), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_edge_outputs", 64'(outs), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - dn0), 64'd0);
        chk_mem("rst_partial");
        run_copy(11'h600, 11'h700, 12'd4, 0, 1'b0, 14, "after_rst");

        // Randomized copies with random stalls.
        rand_stall = 1;
        for (int r = 0; r < 16; r++) begin
            rs = AW'($urandom_range(0, NW - 1));
            rd = AW'($urandom_range(0, NW - 1));
            rn = LW'($urandom_range(0, 24));
            run_copy(rs, rd, rn, -1, 1'b0, -1, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
